// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg: shared types and helpers for the instruction prefetch buffer.
//   FETCH_ENTRY_WIDTH : width of one buffered entry {pc_4, instruction}
//   fetch_entry_t     : packed buffered entry
//   count_width()     : bits needed to count 0..depth inclusive
package fetch_buffer_pkg;

  localparam int unsigned FETCH_ENTRY_WIDTH = 64;

  typedef struct packed {
    logic [31:0] pc_4;
    logic [31:0] instruction;
  } fetch_entry_t;

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if: memory request/response, pipeline control and IF/ID head signals.
//   master modport : the prefetch buffer (drives requests and head outputs)
//   slave modport  : memory + pipeline side (drives ready/response/redirect/stall)
interface fetch_buffer_if #(
  parameter int unsigned DEPTH = 4
);
  import fetch_buffer_pkg::*;

  localparam int unsigned CW = count_width(DEPTH);

  logic          mem_request_valid;
  logic          mem_request_ready;
  logic [31:0]   mem_request_address;
  logic          mem_response_valid;
  logic [31:0]   mem_response_data;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          stall;
  logic          out_valid;
  logic [31:0]   out_pc_4;
  logic [31:0]   out_instruction;
  logic [CW-1:0] occupancy;

  modport master (
    output mem_request_valid, mem_request_address,
    output out_valid, out_pc_4, out_instruction, occupancy,
    input  mem_request_ready, mem_response_valid, mem_response_data,
    input  redirect, redirect_pc, stall
  );

  modport slave (
    input  mem_request_valid, mem_request_address,
    input  out_valid, out_pc_4, out_instruction, occupancy,
    output mem_request_ready, mem_response_valid, mem_response_data,
    output redirect, redirect_pc, stall
  );

endinterface

// File: rtl/fetch_buffer_ring.sv
// fetch_buffer_ring: DEPTH-entry ring buffer with push, pop and flush.
//   clock, reset   : rising-edge clock, async active-low reset
//   i_push/entry   : write entry at tail
//   i_pop          : advance head (ignored when empty)
//   i_flush        : drop all entries (wins over push/pop)
//   o_head_valid   : registered, head entry present
//   o_head_entry   : registered head entry, zero when empty
//   o_count        : registered number of entries
module fetch_buffer_ring
  import fetch_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = count_width(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_push,
  input  fetch_entry_t  i_push_entry,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic          o_head_valid,
  output fetch_entry_t  o_head_entry,
  output logic [CW-1:0] o_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [FETCH_ENTRY_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic           r_head_valid;
  fetch_entry_t   r_head_entry;

  logic           w_pop;
  logic [PW-1:0]  w_head_inc;
  logic [CW-1:0]  w_count_next;
  fetch_entry_t   w_head_entry_next;

  assign w_pop      = i_pop && r_head_valid;
  assign w_head_inc = r_head + PW'(1);

  // The head is kept in its own register so the outputs never see the
  // array read mux; the next head comes from the push data when the buffer
  // is (or becomes) otherwise empty, else from the slot behind the head.
  always_comb begin
    w_count_next = r_count;
    if (i_push && !w_pop)      w_count_next = r_count + CW'(1);
    else if (!i_push && w_pop) w_count_next = r_count - CW'(1);

    w_head_entry_next = r_head_entry;
    if (w_count_next == '0)
      w_head_entry_next = '0;
    else if (r_count == '0 || (w_pop && r_count == CW'(1)))
      w_head_entry_next = i_push_entry;
    else if (w_pop)
      w_head_entry_next = fetch_entry_t'(r_mem[w_head_inc]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_head_valid <= 1'b0;
      r_head_entry <= '0;
    end else if (i_flush) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_head_valid <= 1'b0;
      r_head_entry <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= w_head_inc;
      r_count      <= w_count_next;
      r_head_valid <= (w_count_next != '0);
      r_head_entry <= w_head_entry_next;
    end
  end

  always_ff @(posedge clock) begin
    if (i_push && !i_flush) r_mem[r_tail] <= i_push_entry;
  end

  assign o_head_valid = r_head_valid;
  assign o_head_entry = r_head_entry;
  assign o_count      = r_count;

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction prefetch buffer between a variable-latency
// instruction memory and the IF/ID registers.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : fetch_buffer_if.master -- memory request/response, redirect,
//           stall, head outputs (out_valid/out_pc_4/out_instruction) and occupancy
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clock,
  input  logic          reset,
  fetch_buffer_if.master bus
);

  localparam int unsigned   CW        = count_width(DEPTH);
  localparam logic [CW:0]   DEPTH_LIM = DEPTH[CW:0];

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_in_flight;
  logic [CW-1:0] r_drop_count;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_credit_used;
  logic [CW-1:0] w_in_flight_after_resp;
  logic [31:0]   w_redirect_pc;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_resp_keep;
  logic          w_pop;
  logic          w_head_valid;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head_entry;

  assign w_redirect_pc = {bus.redirect_pc[31:2], 2'b00};

  // Credits cover both buffered and in-flight fetches so every kept
  // response is guaranteed a free slot.
  assign w_credit_used = {1'b0, w_count} + {1'b0, r_in_flight};
  assign w_req_valid   = reset && !bus.redirect && (w_credit_used < DEPTH_LIM);
  assign w_req_fire    = w_req_valid && bus.mem_request_ready;

  assign w_resp_keep   = bus.mem_response_valid && (r_drop_count == '0) && !bus.redirect;
  assign w_pop         = w_head_valid && !bus.stall && !bus.redirect;
  assign w_push_entry  = fetch_entry_t'{pc_4: r_resp_pc + 32'd4, instruction: bus.mem_response_data};

  assign w_in_flight_after_resp = r_in_flight - CW'(bus.mem_response_valid);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fetch_pc   <= RESET_PC;
      r_resp_pc    <= RESET_PC;
      r_in_flight  <= '0;
      r_drop_count <= '0;
    end else if (bus.redirect) begin
      // Everything still outstanding belongs to the old path; a response
      // arriving this cycle is discarded here and so is not counted again.
      r_fetch_pc   <= w_redirect_pc;
      r_resp_pc    <= w_redirect_pc;
      r_in_flight  <= w_in_flight_after_resp;
      r_drop_count <= w_in_flight_after_resp;
    end else begin
      if (w_req_fire)  r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_resp_keep) r_resp_pc  <= r_resp_pc + 32'd4;
      r_in_flight <= w_in_flight_after_resp + CW'(w_req_fire);
      if (bus.mem_response_valid && (r_drop_count != '0))
        r_drop_count <= r_drop_count - CW'(1);
    end
  end

  fetch_buffer_ring #(.DEPTH(DEPTH)) u_ring (
    .clock        (clock),
    .reset        (reset),
    .i_push       (w_resp_keep),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush      (bus.redirect),
    .o_head_valid (w_head_valid),
    .o_head_entry (w_head_entry),
    .o_count      (w_count)
  );

  assign bus.mem_request_valid   = w_req_valid;
  assign bus.mem_request_address = r_fetch_pc;
  assign bus.out_valid           = w_head_valid;
  assign bus.out_pc_4            = w_head_entry.pc_4;
  assign bus.out_instruction     = w_head_entry.instruction;
  assign bus.occupancy           = w_count;

endmodule
